baud_gen: RTL and testbench
===========================

BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 SHALL provide parameter CNT_W, default 20, width of integer divisor and interval counter.
REQ-002 SHALL provide parameter FRAC_W, default 4, width of fractional divisor and phase accumulator.
REQ-003 SHALL provide parameter OSR, default 16, oversample ticks per baud period; power of two, at least 2.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port en  input  1  run enable; 0 = idle.
REQ-007 SHALL provide port div_int  input  CNT_W  integer part of clocks per oversample tick.
REQ-008 SHALL provide port div_frac  input  FRAC_W  fractional part, units of 1/2^FRAC_W clock.
REQ-009 SHALL provide port load  input  1  capture div_int/div_frac into shadow registers.
REQ-010 SHALL provide port sync  input  1  restart phase (counter, os_count, accumulator).
REQ-011 SHALL provide port os_tick  output  1  one-clock pulse per oversample interval.
REQ-012 SHALL provide port baud_tick  output  1  one-clock pulse per OSR oversample ticks.
REQ-013 SHALL provide port baud_clk  output  1  baud-rate square wave.
REQ-014 SHALL provide port os_count  output  log2(OSR)  oversample index within baud period.
REQ-015 SHALL provide port div_err  output  1  active shadow integer divisor below 2.

Function
REQ-016 SHALL implement two states: IDLE and RUN.
REQ-017 IDLE->RUN SHALL occur on the edge sampling en=1 with active div_int >= 2; interval counter, os_count, accumulator = 0 after that edge.
REQ-018 RUN->IDLE SHALL occur on the edge sampling en=0; counter, os_count, accumulator cleared, all outputs low except div_err.
REQ-019 With en=1 and active div_int < 2, block SHALL remain IDLE with div_err=1 and no ticks; div_err SHALL be 0 otherwise.
REQ-020 load=1 in IDLE SHALL update active shadow divisor on that edge; load=1 in RUN SHALL update pending registers, applied at the next interval start.
REQ-021 Each interval length P SHALL be fixed at interval start: sum = acc + div_frac (FRAC_W+1 bits); P = div_int + carry; acc <= sum low FRAC_W bits.
REQ-022 os_tick SHALL be registered, high exactly one clock, on the P-th rising edge after interval start; next interval starts on that same edge.
REQ-023 os_count SHALL increment on each os_tick edge, wrapping OSR-1 -> 0.
REQ-024 baud_tick SHALL pulse coincident with the os_tick on which os_count wraps OSR-1 -> 0.
REQ-025 baud_clk SHALL be registered, high while os_count < OSR/2 in RUN, low otherwise.
REQ-026 Counter SHALL not overflow: CNT_W-bit compare against P-1, with P = 2^CNT_W (div_int all ones plus carry) handled by a CNT_W+1-bit counter.
REQ-027 sync=1 in RUN SHALL restart a new interval on that edge (counter, os_count, acc = 0) and suppress any tick due that edge; sync SHALL take priority over tick, load application and en=1.
REQ-028 en=0 SHALL take priority over sync and tick on the same edge.
REQ-029 load and interval start on the same edge SHALL apply the newly loaded value to the following interval, not the current one.

Reset
REQ-030 rstn=0 SHALL immediately force IDLE; os_tick, baud_tick, baud_clk, os_count, counter, accumulator = 0; shadow and pending div_int = 20, div_frac = 0; div_err = 0.
REQ-031 Reset release SHALL take effect on the first rising edge with rstn=1; no ticks before en is sampled high.
REQ-032 Reset asserted mid-interval SHALL discard all phase; after release and en=1, first os_tick follows full P clocks.

Verification
REQ-033 Defaults, div_int=20, frac=0, en=1 after reset -> os_tick every 20 clocks, baud_tick every 320, baud_clk 160 high/160 low.
REQ-034 div_int=10, div_frac=8 loaded in IDLE, en=1 -> intervals 10,11,10,11...; 16 os_ticks span 168 clocks.
REQ-035 div_int=1 loaded, en=1 -> div_err=1, state IDLE, no ticks; load div_int=4 -> div_err=0, os_tick every 4 clocks.
REQ-036 Running div_int=20, load div_int=8 at clock 5 of an interval -> current interval stays 20, subsequent 8.
REQ-037 sync at clock 7 of interval with os_count=5 -> no tick, os_count=0, next os_tick 20 clocks later; en=0 same edge -> IDLE, outputs low.
REQ-038 rstn low for 3 clocks mid-baud-period -> outputs 0 asynchronously; after release and en=1, first os_tick after 20 clocks.

Source files
------------

// File: rtl/baud_gen.sv
// Fractional-N baud rate generator.
// Produces an oversample tick every div_int + div_frac/2^FRAC_W clocks on
// average, a baud tick every OSR oversample ticks, and a baud square wave.
// Each interval length is fixed when the interval starts. A phase accumulator
// stretches an interval by one clock whenever the fractional sum carries.
module baud_gen #(
  parameter int CNT_W  = 20,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [CNT_W-1:0]          div_int,
  input  logic [FRAC_W-1:0]         div_frac,
  input  logic                      load,
  input  logic                      sync,
  output logic                      os_tick,
  output logic                      baud_tick,
  output logic                      baud_clk,
  output logic [$clog2(OSR)-1:0]    os_count,
  output logic                      div_err
);

  localparam int OS_W = $clog2(OSR);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DIV_MIN   = CNT_W'(2);
  localparam logic [CNT_W-1:0]  DIV_RST   = CNT_W'(20);
  localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};
  localparam logic [OS_W-1:0]   OS_ZERO   = {OS_W{1'b0}};
  localparam logic [OS_W-1:0]   OS_ONE    = OS_W'(1);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OSR - 1);

  // State registers
  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_act_int,  r_pend_int;
  logic [FRAC_W-1:0] r_act_frac, r_pend_frac;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_per_m1;
  logic [FRAC_W-1:0] r_acc;
  logic [OS_W-1:0]   r_os_count;
  logic              r_os_tick, r_baud_tick, r_baud_clk, r_div_err;

  // Next-state values
  logic [0:0]        w_nx_state;
  logic [CNT_W-1:0]  w_nx_act_int,  w_nx_pend_int;
  logic [FRAC_W-1:0] w_nx_act_frac, w_nx_pend_frac;
  logic [CNT_W-1:0]  w_nx_cnt, w_nx_per_m1;
  logic [FRAC_W-1:0] w_nx_acc;
  logic [OS_W-1:0]   w_nx_os;
  logic              w_nx_os_tick, w_nx_baud_tick, w_nx_baud_clk, w_nx_div_err;

  // Interval-start arithmetic. A restart (leaving IDLE, or sync) begins from
  // zero phase with the active divisor. A natural interval boundary applies
  // the pending divisor and carries the accumulated phase forward.
  logic              w_restart;
  logic [CNT_W-1:0]  w_st_int;
  logic [FRAC_W-1:0] w_st_frac;
  logic [FRAC_W-1:0] w_st_acc;
  logic [FRAC_W:0]   w_sum;
  logic [CNT_W-1:0]  w_per_m1;
  logic              w_act_ok, w_pend_ok;

  assign w_restart = (r_state == S_IDLE) || sync;
  assign w_st_int  = w_restart ? r_act_int  : r_pend_int;
  assign w_st_frac = w_restart ? r_act_frac : r_pend_frac;
  assign w_st_acc  = w_restart ? FRAC_ZERO  : r_acc;
  assign w_sum     = {1'b0, w_st_acc} + {1'b0, w_st_frac};
  // P-1 = div_int - 1 + carry. This stays within CNT_W bits even when
  // P = 2^CNT_W, so the terminal compare never overflows.
  assign w_per_m1  = w_sum[FRAC_W] ? w_st_int : (w_st_int - CNT_ONE);
  assign w_act_ok  = (r_act_int  >= DIV_MIN);
  assign w_pend_ok = (r_pend_int >= DIV_MIN);

  // Next-state logic: en=0 beats sync, sync beats tick and divisor application.
  always_comb begin
    w_nx_state     = r_state;
    w_nx_act_int   = r_act_int;
    w_nx_act_frac  = r_act_frac;
    w_nx_pend_int  = r_pend_int;
    w_nx_pend_frac = r_pend_frac;
    w_nx_cnt       = r_cnt;
    w_nx_per_m1    = r_per_m1;
    w_nx_acc       = r_acc;
    w_nx_os        = r_os_count;
    w_nx_os_tick   = 1'b0;
    w_nx_baud_tick = 1'b0;
    w_nx_div_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_act_ok) begin
          w_nx_state  = S_RUN;
          w_nx_cnt    = CNT_ZERO;
          w_nx_os     = OS_ZERO;
          w_nx_per_m1 = w_per_m1;
          w_nx_acc    = w_sum[FRAC_W-1:0];
          // A load on the start edge only affects the following interval.
          if (load) begin
            w_nx_pend_int  = div_int;
            w_nx_pend_frac = div_frac;
          end else begin
            w_nx_pend_int  = r_pend_int;
            w_nx_pend_frac = r_pend_frac;
          end
        end else begin
          w_nx_div_err = en && !w_act_ok;
          if (load) begin
            w_nx_act_int   = div_int;
            w_nx_act_frac  = div_frac;
            w_nx_pend_int  = div_int;
            w_nx_pend_frac = div_frac;
          end else begin
            w_nx_act_int   = r_act_int;
            w_nx_act_frac  = r_act_frac;
          end
        end
      end
      S_RUN: begin
        if (!en) begin
          w_nx_state = S_IDLE;
          w_nx_cnt   = CNT_ZERO;
          w_nx_os    = OS_ZERO;
          w_nx_acc   = FRAC_ZERO;
        end else if (sync) begin
          w_nx_cnt    = CNT_ZERO;
          w_nx_os     = OS_ZERO;
          w_nx_per_m1 = w_per_m1;
          w_nx_acc    = w_sum[FRAC_W-1:0];
        end else if (r_cnt == r_per_m1) begin
          w_nx_os_tick   = 1'b1;
          w_nx_baud_tick = (r_os_count == OS_LAST);
          w_nx_os        = (r_os_count == OS_LAST) ? OS_ZERO : (r_os_count + OS_ONE);
          w_nx_cnt       = CNT_ZERO;
          w_nx_act_int   = r_pend_int;
          w_nx_act_frac  = r_pend_frac;
          // An unusable pending divisor stops the generator; div_err follows.
          if (w_pend_ok) begin
            w_nx_per_m1 = w_per_m1;
            w_nx_acc    = w_sum[FRAC_W-1:0];
          end else begin
            w_nx_state = S_IDLE;
            w_nx_os    = OS_ZERO;
            w_nx_acc   = FRAC_ZERO;
          end
        end else begin
          w_nx_cnt = r_cnt + CNT_ONE;
        end
        if (load) begin
          w_nx_pend_int  = div_int;
          w_nx_pend_frac = div_frac;
        end else begin
          w_nx_pend_int  = r_pend_int;
          w_nx_pend_frac = r_pend_frac;
        end
      end
      default: begin
        w_nx_state = S_IDLE;
        w_nx_cnt   = CNT_ZERO;
        w_nx_os    = OS_ZERO;
        w_nx_acc   = FRAC_ZERO;
      end
    endcase
    w_nx_baud_clk = (w_nx_state == S_RUN) && !w_nx_os[OS_W-1];
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_act_int   <= DIV_RST;
      r_act_frac  <= FRAC_ZERO;
      r_pend_int  <= DIV_RST;
      r_pend_frac <= FRAC_ZERO;
      r_cnt       <= CNT_ZERO;
      r_per_m1    <= CNT_ZERO;
      r_acc       <= FRAC_ZERO;
      r_os_count  <= OS_ZERO;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
      r_baud_clk  <= 1'b0;
      r_div_err   <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_act_int   <= w_nx_act_int;
      r_act_frac  <= w_nx_act_frac;
      r_pend_int  <= w_nx_pend_int;
      r_pend_frac <= w_nx_pend_frac;
      r_cnt       <= w_nx_cnt;
      r_per_m1    <= w_nx_per_m1;
      r_acc       <= w_nx_acc;
      r_os_count  <= w_nx_os;
      r_os_tick   <= w_nx_os_tick;
      r_baud_tick <= w_nx_baud_tick;
      r_baud_clk  <= w_nx_baud_clk;
      r_div_err   <= w_nx_div_err;
    end
  end

  assign os_tick   = r_os_tick;
  assign baud_tick = r_baud_tick;
  assign baud_clk  = r_baud_clk;
  assign os_count  = r_os_count;
  assign div_err   = r_div_err;

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: a table of divisor settings with
// hand-computed interval lengths, plus directed multi-cycle sequences.
module tb_baud_gen;

  localparam int CNT_W  = 20;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int OS_W   = 4;

  logic              clk = 1'b0;
  logic              rstn, en, load, sync;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick, baud_tick, baud_clk, div_err;
  logic [OS_W-1:0]   os_count;

  int checks   = 0;
  int failures = 0;

  baud_gen #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
    .clk(clk), .rstn(rstn), .en(en), .div_int(div_int), .div_frac(div_frac),
    .load(load), .sync(sync), .os_tick(os_tick), .baud_tick(baud_tick),
    .baud_clk(baud_clk), .os_count(os_count), .div_err(div_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int di;
    int df;
    int p0, p1, p2, p3;   // first four interval lengths
    int span;             // clocks covered by 16 os_ticks
    bit err;              // divisor is illegal
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts rising edges until os_tick is seen (sampled 1 time unit after edge).
  task automatic wait_tick(output int n, input int lim);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (os_tick) begin
        done = 1'b1;
      end else if (n >= lim) begin
        checks++;
        failures++;
        $display("FAIL tick_timeout: got no os_tick in %0d clocks expected one", lim);
        done = 1'b1;
      end
    end
  endtask

  // Counts os_ticks over a window of clocks.
  task automatic count_ticks(output int t, input int clocks);
    t = 0;
    for (int i = 0; i < clocks; i++) begin
      @(posedge clk);
      #1;
      if (os_tick) t++;
    end
  endtask

  // Stop, load a divisor in IDLE, enable; returns just after the start edge.
  task automatic go_idle_load(input int di, input int df);
    @(negedge clk); en = 1'b0; load = 1'b0; sync = 1'b0;
    @(negedge clk); load = 1'b1; div_int = CNT_W'(di); div_frac = FRAC_W'(df);
    @(negedge clk); load = 1'b0; en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, t, sum, hi, bt1, bt2, first_tick;

    vecs[0] = '{di: 20, df: 0,  p0: 20, p1: 20, p2: 20, p3: 20, span: 320, err: 1'b0};
    vecs[1] = '{di: 10, df: 8,  p0: 10, p1: 11, p2: 10, p3: 11, span: 168, err: 1'b0};
    vecs[2] = '{di: 4,  df: 0,  p0: 4,  p1: 4,  p2: 4,  p3: 4,  span: 64,  err: 1'b0};
    vecs[3] = '{di: 2,  df: 0,  p0: 2,  p1: 2,  p2: 2,  p3: 2,  span: 32,  err: 1'b0};
    vecs[4] = '{di: 3,  df: 15, p0: 3,  p1: 4,  p2: 4,  p3: 4,  span: 63,  err: 1'b0};
    vecs[5] = '{di: 5,  df: 4,  p0: 5,  p1: 5,  p2: 5,  p3: 6,  span: 84,  err: 1'b0};
    vecs[6] = '{di: 1,  df: 0,  p0: 0,  p1: 0,  p2: 0,  p3: 0,  span: 0,   err: 1'b1};
    vecs[7] = '{di: 0,  df: 9,  p0: 0,  p1: 0,  p2: 0,  p3: 0,  span: 0,   err: 1'b1};

    rstn = 1'b0; en = 1'b0; load = 1'b0; sync = 1'b0;
    div_int = '0; div_frac = '0;

    // Reset state
    #12;
    check("rst_os_tick",   int'(os_tick),   0);
    check("rst_baud_tick", int'(baud_tick), 0);
    check("rst_baud_clk",  int'(baud_clk),  0);
    check("rst_os_count",  int'(os_count),  0);
    check("rst_div_err",   int'(div_err),   0);

    // No ticks while en is low after release
    @(negedge clk); rstn = 1'b1;
    count_ticks(t, 25);
    check("idle_no_ticks", t, 0);
    check("idle_div_err", int'(div_err), 0);

    // Default divisor 20/0: os_tick every 20, baud_tick every 320, 160/160 baud_clk
    @(negedge clk); en = 1'b1;
    @(posedge clk);
    hi = 0; bt1 = -1; bt2 = -1; first_tick = -1; t = 0;
    for (int k = 0; k <= 640; k++) begin
      if (k > 0) @(negedge clk);
      else @(negedge clk);
      if (k < 320 && baud_clk) hi++;
      if (k >= 1 && k <= 320 && os_tick) t++;
      if (os_tick && first_tick < 0) first_tick = k;
      if (baud_tick && bt1 < 0) bt1 = k;
      else if (baud_tick && bt2 < 0) bt2 = k;
    end
    check("dflt_first_os_tick", first_tick, 20);
    check("dflt_os_ticks_per_baud", t, 16);
    check("dflt_baud_clk_high", hi, 160);
    check("dflt_first_baud_tick", bt1, 320);
    check("dflt_baud_period", bt2 - bt1, 320);

    // Table of divisor settings
    for (int i = 0; i < 8; i++) begin
      go_idle_load(vecs[i].di, vecs[i].df);
      if (vecs[i].err) begin
        count_ticks(t, 40);
        check($sformatf("v%0d_err_no_ticks", i), t, 0);
        check($sformatf("v%0d_div_err", i), int'(div_err), 1);
      end else begin
        check($sformatf("v%0d_div_err", i), int'(div_err), 0);
        sum = 0;
        for (int k = 0; k < 16; k++) begin
          wait_tick(n, 100);
          sum += n;
          if (k == 0) check($sformatf("v%0d_p0", i), n, vecs[i].p0);
          if (k == 1) check($sformatf("v%0d_p1", i), n, vecs[i].p1);
          if (k == 2) check($sformatf("v%0d_p2", i), n, vecs[i].p2);
          if (k == 3) check($sformatf("v%0d_p3", i), n, vecs[i].p3);
          if (k == 0) check($sformatf("v%0d_no_baud_tick", i), int'(baud_tick), 0);
          if (k == 15) begin
            check($sformatf("v%0d_baud_tick", i), int'(baud_tick), 1);
            check($sformatf("v%0d_os_wrap", i), int'(os_count), 0);
          end
        end
        check($sformatf("v%0d_span", i), sum, vecs[i].span);
      end
    end

    // Illegal divisor then legal reload while enabled
    go_idle_load(1, 0);
    count_ticks(t, 10);
    check("err_no_ticks", t, 0);
    check("err_flag", int'(div_err), 1);
    @(negedge clk); load = 1'b1; div_int = CNT_W'(4); div_frac = '0;
    @(posedge clk);
    @(negedge clk); load = 1'b0;
    @(posedge clk);
    #1;
    check("reload_err_clear", int'(div_err), 0);
    wait_tick(n, 100); check("reload_p0", n, 4);
    wait_tick(n, 100); check("reload_p1", n, 4);

    // Load in RUN at clock 5 of an interval: current stays 20, then 8
    go_idle_load(20, 0);
    repeat (4) @(posedge clk);
    @(negedge clk); load = 1'b1; div_int = CNT_W'(8);
    @(posedge clk);
    @(negedge clk); load = 1'b0;
    wait_tick(n, 100); check("runload_rest_of_20", n, 15);
    wait_tick(n, 100); check("runload_next_8", n, 8);
    wait_tick(n, 100); check("runload_then_8", n, 8);

    // Sync at clock 7 of an interval with os_count = 5
    go_idle_load(20, 0);
    for (int k = 0; k < 5; k++) wait_tick(n, 100);
    check("sync_pre_os_count", int'(os_count), 5);
    repeat (6) @(posedge clk);
    @(negedge clk); sync = 1'b1;
    @(posedge clk);
    #1;
    check("sync_no_tick", int'(os_tick), 0);
    check("sync_os_count", int'(os_count), 0);
    @(negedge clk); sync = 1'b0;
    wait_tick(n, 100); check("sync_next_tick", n, 20);
    check("sync_os_count_after", int'(os_count), 1);

    // Sync exactly on the edge a tick is due: tick suppressed
    repeat (19) @(posedge clk);
    @(negedge clk); sync = 1'b1;
    @(posedge clk);
    #1;
    check("sync_due_no_tick", int'(os_tick), 0);
    check("sync_due_os_count", int'(os_count), 0);
    @(negedge clk); sync = 1'b0;
    wait_tick(n, 100); check("sync_due_next_tick", n, 20);

    // en=0 together with sync: goes IDLE with outputs low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stop_pre_baud_clk", int'(baud_clk), 1);
    en = 1'b0; sync = 1'b1;
    @(posedge clk);
    #1;
    check("stop_os_count", int'(os_count), 0);
    check("stop_baud_clk", int'(baud_clk), 0);
    check("stop_os_tick", int'(os_tick), 0);
    @(negedge clk); sync = 1'b0;
    count_ticks(t, 30);
    check("stop_no_ticks", t, 0);

    // Reset mid-baud-period: outputs clear at once, defaults restored
    go_idle_load(8, 0);
    for (int k = 0; k < 3; k++) wait_tick(n, 100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst2_pre_os_count", int'(os_count), 3);
    check("rst2_pre_baud_clk", int'(baud_clk), 1);
    #2 rstn = 1'b0;
    #1;
    check("rst2_os_count", int'(os_count), 0);
    check("rst2_baud_clk", int'(baud_clk), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk);
    #1;
    wait_tick(n, 100); check("rst2_first_tick", n, 20);
    check("rst2_os_count_after", int'(os_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
